blink_monitor: RTL and testbench
================================

Name: blink_monitor

Overview:
- Receive-side counterpart of the LED blink generator. Measures an incoming square wave, such as a looped-back LED line or an external blinker pin, in the clk0 domain.
- Synchronizes the input and times consecutive rising edges. Reports period and high time through a valid/ready interface, so the ILA or a host can read blink-rate measurements.
- Flags a stuck or absent input with a timeout, and flags dropped measurements with an overrun bit.

Parameters:
- CNT_W, 27, width of the period/high-time counters and outputs.
- TIMEOUT_CYC, 2**27-2, number of clk0 cycles without a rising edge before the stuck condition. Must be <= 2**CNT_W-2.

Ports:
- clk0  in  1  measurement clock (PLL CLK0 output).
- rst  in  1  synchronous, active-low reset.
- sig_in  in  1  asynchronous blink input.
- period  out  CNT_W  clk0 cycles between the last two rising edges.
- high_time  out  CNT_W  cycles sig was high within that period.
- period_valid  out  1  measurement available.
- period_ready  in  1  consumer accepts the measurement.
- overrun  out  1  sticky: a measurement was dropped.
- stuck  out  1  no rising edge within TIMEOUT_CYC cycles.
- level  out  1  synchronized sig_in level.

Behaviour:
- Reset: rst is synchronous, active-low, and clocked by clk0. While rst=0, all outputs and internal registers are 0 and the FSM is in IDLE.
- Synchronizer: sig_in passes through s1 -> s2 -> s3 flops. level = s2. Rising edge rise = s2 & ~s3.
- Edge latency: sig_in rising before clk0 edge 0 gives rise=1 during cycle 2. Outputs update at clk0 edge 3.
- FSM states:
  - IDLE: on rise, go to MEASURE, cnt<=1, hcnt<=1. No output is produced.
  - MEASURE, on a non-rise cycle: cnt<=cnt+1; hcnt<=hcnt+s2.
  - MEASURE, on rise: capture period<=cnt and high_time<=hcnt. Reload cnt<=1, hcnt<=1. Stay in MEASURE.
  - MEASURE, when cnt==TIMEOUT_CYC and rise=0: go to IDLE, stuck<=1, cnt<=0, hcnt<=0.
- Period arithmetic: a square wave of period P cycles with H high cycles reports period=P and high_time=H. Counters never wrap because the timeout fires first.
- stuck clears on the next rise, which is the arming edge in IDLE.
- Handshake:
  - A capture sets period_valid=1.
  - Acceptance is period_valid & period_ready in the same cycle. On acceptance, period_valid<=0 unless a capture occurs in that same cycle.
  - Capture and accept in the same cycle: new data is loaded and period_valid stays 1.
  - Capture while period_valid=1 and period_ready=0: the held data is kept, the new measurement is dropped, and overrun<=1.
- period and high_time are stable while period_valid=1.
- overrun is cleared only by reset.
- Reset mid-measurement: in-flight counts are discarded. After reset, the first rise only arms.

Optional Feature:
- Macro: BLINK_MON_DUTY_EN.
- Defined: the hcnt counter is present and high_time reports high cycles as specified above.
- Undefined: hcnt logic is removed and high_time is tied to 0. The port list is unchanged, and all other behaviour is identical.

Test Plan:
Tests 1, 2 and 6 run with TIMEOUT_CYC=1000 and BLINK_MON_DUTY_EN defined.
1. Square wave, period 16, high 8, period_ready=1 -> first edge arms only. At each later edge: period=16, high_time=8, period_valid pulses 1 cycle.
2. Hold period_ready=0 and drive three rising edges 20 cycles apart -> period=20 captured and held, period_valid=1. After the third edge, overrun=1 with data unchanged. Raising ready for 1 cycle then clears period_valid.
3. TIMEOUT_CYC=1000. Rise, then hold sig_in high -> stuck=1 exactly 1000 cycles after counting starts, level=1. The next rise clears stuck. The following rise at +30 cycles yields period=30.
4. Pulse rst=0 for 2 cycles in the middle of a 50-cycle measurement -> all outputs 0 during reset. The next edge produces no output, and the edge after it reports the correct period.
5. sig_in rises at edge 0 as the second edge of a 12-cycle wave -> period_valid=1 and period=12 first visible after clk0 edge 3.
6. Assert period_ready in the same cycle as a new capture -> new values loaded, period_valid remains 1, overrun stays 0.

Source files
------------

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - measures period and high time of an asynchronous blink input
//
// Purpose:
//   Synchronizes sig_in into the clk0 domain and times consecutive rising
//   edges. Each measurement (period, high_time) is offered on a valid/ready
//   handshake. A missing edge for TIMEOUT_CYC cycles raises stuck. A
//   measurement dropped while the previous one is still unaccepted raises
//   the sticky overrun flag.
//
// Optional feature macro: BLINK_MON_DUTY_EN
//   defined   - high-time counter present, high_time reports high cycles
//   undefined - high-time counter removed, high_time tied to 0
//
// Ports:
//   clk0          in   1      measurement clock
//   rst           in   1      synchronous active-low reset
//   sig_in        in   1      asynchronous blink input
//   period        out  CNT_W  clk0 cycles between the last two rising edges
//   high_time     out  CNT_W  cycles the input was high within that period
//   period_valid  out  1      measurement available
//   period_ready  in   1      consumer accepts the measurement
//   overrun       out  1      sticky: a measurement was dropped
//   stuck         out  1      no rising edge within TIMEOUT_CYC cycles
//   level         out  1      synchronized input level

module blink_monitor #(
    parameter int CNT_W       = 27,
    parameter int TIMEOUT_CYC = 2**27 - 2
) (
    input  logic             clk0,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             stuck,
    output logic             level
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYC);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_valid;
    logic             r_overrun;
    logic             r_stuck;
    logic [CNT_W-1:0] w_hcnt;

    logic w_arm;
    logic w_capture;
    logic w_timeout;
    logic w_count;
    logic w_at_limit;

    // Three-flop synchronizer. The edge pulse is registered so the FSM works
    // from a flop; r_s3 is the level aligned with r_rise, which makes the
    // edge-to-output latency three clk0 edges.
    always_ff @(posedge clk0) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= sig_in;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_rise <= r_s2 & ~r_s3;
        end
    end

    assign w_at_limit = (r_cnt == CNT_TIMEOUT);

    // FSM: state register
    always_ff @(posedge clk0) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_rise) begin
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!r_rise && w_at_limit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: per-cycle actions for the datapath
    always_comb begin
        w_arm     = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_count   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_arm = r_rise;
            end
            S_MEASURE: begin
                w_capture = r_rise;
                w_timeout = !r_rise && w_at_limit;
                w_count   = !r_rise && !w_at_limit;
            end
            default: begin
                w_arm = 1'b0;
            end
        endcase
    end

    // Period counter, stuck flag and output handshake
    always_ff @(posedge clk0) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_stuck     <= 1'b0;
        end else begin
            // The rise cycle itself is the first cycle of the new period.
            if (w_arm || w_capture) begin
                r_cnt <= CNT_ONE;
            end else if (w_timeout) begin
                r_cnt <= '0;
            end else if (w_count) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            if (w_timeout) begin
                r_stuck <= 1'b1;
            end else if (w_arm) begin
                r_stuck <= 1'b0;
            end

            // A capture may load only when the held word is gone or is being
            // accepted this very cycle; otherwise the new one is dropped.
            if (w_capture && (!r_valid || period_ready)) begin
                r_period    <= r_cnt;
                r_high_time <= w_hcnt;
                r_valid     <= 1'b1;
            end else begin
                if (w_capture) begin
                    r_overrun <= 1'b1;
                end
                if (r_valid && period_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

`ifdef BLINK_MON_DUTY_EN
    logic [CNT_W-1:0] r_hcnt;

    always_ff @(posedge clk0) begin
        if (!rst) begin
            r_hcnt <= '0;
        end else begin
            if (w_arm || w_capture) begin
                r_hcnt <= CNT_ONE;
            end else if (w_timeout) begin
                r_hcnt <= '0;
            end else if (w_count) begin
                r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, r_s3};
            end
        end
    end

    assign w_hcnt = r_hcnt;
`else
    assign w_hcnt = '0;
`endif

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_valid;
    assign overrun      = r_overrun;
    assign stuck        = r_stuck;
    assign level        = r_s2;

endmodule

// File: tb/tb_blink_monitor.sv
// tb/tb_blink_monitor.sv - directed self-checking bench for blink_monitor

module tb_blink_monitor;

    localparam int CNT_W   = 27;
    localparam int TIMEOUT = 1000;

    logic             clk0;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             period_ready;
    logic             overrun;
    logic             stuck;
    logic             level;

    int n_assert = 0;
    int n_fail   = 0;

    blink_monitor #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk0         (clk0),
        .rst          (rst),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overrun      (overrun),
        .stuck        (stuck),
        .level        (level)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // Expected high_time for a given high count, depending on the build.
    function automatic int hexp(input int h);
`ifdef BLINK_MON_DUTY_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk0);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        sig_in = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
    endtask

    task automatic wave(input int hi, input int per);
        sig_in = 1'b1;
        for (int i = 0; i < per; i++) begin
            if (i == hi) sig_in = 1'b0;
            step(1);
        end
    endtask

    // One wave starting with a rise; ready must be 1. The capture caused by
    // this rise is visible right after clk0 edge 3 (loop index 3) and is a
    // one-cycle pulse.
    task automatic wave_chk(input int hi, input int per, input int exp_v,
                            input int exp_p, input int exp_h, input string tag);
        sig_in = 1'b1;
        for (int i = 0; i < per; i++) begin
            if (i == hi) sig_in = 1'b0;
            step(1);
            if (i == 2) begin
                check({tag, " valid_edge2"}, int'(period_valid), 0);
                check({tag, " level"}, int'(level), 1);
            end
            if (i == 3) begin
                check({tag, " valid_edge3"}, int'(period_valid), exp_v);
                check({tag, " period"}, int'(period), exp_p);
                check({tag, " high_time"}, int'(high_time), exp_h);
            end
            if (i == 4) check({tag, " valid_pulse_end"}, int'(period_valid), 0);
        end
    endtask

    initial begin
        rst          = 1'b0;
        sig_in       = 1'b1;
        period_ready = 1'b0;
        step(3);
        check("rst period", int'(period), 0);
        check("rst high_time", int'(high_time), 0);
        check("rst valid", int'(period_valid), 0);
        check("rst overrun", int'(overrun), 0);
        check("rst stuck", int'(stuck), 0);
        check("rst level", int'(level), 0);

        // 1: 16-cycle square wave, 8 high, consumer always ready
        do_reset();
        period_ready = 1'b1;
        wave_chk(8, 16, 0, 0, 0, "t1 arm");
        wave_chk(8, 16, 1, 16, hexp(8), "t1 e2");
        wave_chk(8, 16, 1, 16, hexp(8), "t1 e3");
        check("t1 overrun", int'(overrun), 0);

        // 5: latency of the second edge of a 12-cycle wave
        do_reset();
        period_ready = 1'b1;
        wave_chk(6, 12, 0, 0, 0, "t5 arm");
        wave_chk(6, 12, 1, 12, hexp(6), "t5 e2");

        // 2: consumer stalled, second capture dropped
        do_reset();
        period_ready = 1'b0;
        wave(10, 20);
        wave(6, 20);
        check("t2 held valid", int'(period_valid), 1);
        check("t2 held period", int'(period), 20);
        check("t2 held high", int'(high_time), hexp(10));
        check("t2 no overrun yet", int'(overrun), 0);
        wave(10, 20);
        check("t2 overrun", int'(overrun), 1);
        check("t2 kept period", int'(period), 20);
        check("t2 kept high", int'(high_time), hexp(10));
        check("t2 still valid", int'(period_valid), 1);
        period_ready = 1'b1;
        step(1);
        period_ready = 1'b0;
        check("t2 accepted", int'(period_valid), 0);
        check("t2 overrun sticky", int'(overrun), 1);

        // 6: capture and accept in the same cycle
        do_reset();
        period_ready = 1'b0;
        wave(8, 16);
        wave(5, 12);
        sig_in = 1'b1;
        step(3);
        check("t6 held valid", int'(period_valid), 1);
        check("t6 held period", int'(period), 16);
        period_ready = 1'b1;
        step(1);
        period_ready = 1'b0;
        check("t6 valid", int'(period_valid), 1);
        check("t6 period", int'(period), 12);
        check("t6 high", int'(high_time), hexp(5));
        check("t6 overrun", int'(overrun), 0);
        sig_in = 1'b0;
        step(5);

        // 3: stuck-high input times out 1000 cycles after arming
        do_reset();
        period_ready = 1'b1;
        sig_in = 1'b1;
        step(1003);
        check("t3 stuck early", int'(stuck), 0);
        step(1);
        check("t3 stuck", int'(stuck), 1);
        check("t3 level", int'(level), 1);
        check("t3 no valid", int'(period_valid), 0);
        sig_in = 1'b0;
        step(5);
        check("t3 stuck held", int'(stuck), 1);
        sig_in = 1'b1;
        step(4);
        check("t3 stuck cleared", int'(stuck), 0);
        check("t3 rearm no valid", int'(period_valid), 0);
        step(11);
        sig_in = 1'b0;
        step(15);
        sig_in = 1'b1;
        step(4);
        check("t3 valid", int'(period_valid), 1);
        check("t3 period", int'(period), 30);
        check("t3 high", int'(high_time), hexp(15));

        // 4: reset in the middle of a 50-cycle measurement
        do_reset();
        period_ready = 1'b1;
        wave(25, 50);
        wave(25, 50);
        sig_in = 1'b1;
        step(25);
        sig_in = 1'b0;
        step(10);
        rst = 1'b0;
        step(2);
        check("t4 rst period", int'(period), 0);
        check("t4 rst high", int'(high_time), 0);
        check("t4 rst valid", int'(period_valid), 0);
        check("t4 rst overrun", int'(overrun), 0);
        check("t4 rst stuck", int'(stuck), 0);
        check("t4 rst level", int'(level), 0);
        rst = 1'b1;
        step(13);
        wave_chk(25, 50, 0, 0, 0, "t4 arm");
        wave_chk(25, 50, 1, 50, hexp(25), "t4 e2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
